param_accu: RTL and testbench
=============================

PARAM_ACCU -- requirements
Module: param_accu

Interface
REQ-001 Parameter DATA_W, default 8, input sample width (>=1).
REQ-002 Parameter N, default 4, samples summed per group (>=2).
REQ-003 Parameter OUT_W, default DATA_W+$clog2(N) (=10), result width (>=DATA_W).
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  synchronous discard of the partial group.
REQ-007 data_in  input  DATA_W  unsigned sample.
REQ-008 valid_in  input  1  data_in valid.
REQ-009 ready_in  output  1  block accepts a sample this cycle.
REQ-010 data_out  output  OUT_W  group sum.
REQ-011 valid_out  output  1  data_out valid.
REQ-012 ready_out  input  1  downstream accepts data_out.
REQ-013 ovf  output  1  the current data_out exceeded 2^OUT_W-1 before wrap or saturation.

Function
REQ-014 A sample is accepted when valid_in and ready_in are both high on a rising clk.
REQ-015 Internal state: acc (OUT_W+1 bits), cnt (0..N-1), output register {data_out, valid_out, ovf}.
REQ-016 On accept with cnt<N-1: acc <= acc+data_in, cnt <= cnt+1.
REQ-017 On accept with cnt==N-1: data_out <= final sum, valid_out <= 1, acc <= 0, cnt <= 0; data_out is visible the cycle after the Nth accept (latency 1).
REQ-018 Output transfer occurs when valid_out and ready_out are both high; valid_out then clears unless a new group completes in the same cycle.
REQ-019 While valid_out and not ready_out, data_out, valid_out and ovf hold stable.
REQ-020 ready_in = !(cnt==N-1 && valid_out && !ready_out); partial groups keep accumulating during output stall.
REQ-021 Group completion in the same cycle as an output transfer loads the new sum, and valid_out stays 1 with no bubble.
REQ-022 clr high: acc <= 0, cnt <= 0; any sample presented that cycle is dropped; ready_in is unaffected; a pending data_out is not affected.
REQ-023 clr has priority over a simultaneous accept; a group completing in that cycle is discarded.
REQ-024 Sums are unsigned; overflow occurs when the full-precision group sum exceeds 2^OUT_W-1.
REQ-025 ovf is registered alongside data_out and is 0 when no overflow occurred.

Reset
REQ-026 rst_n low asynchronously forces acc=0, cnt=0, data_out=0, valid_out=0, ovf=0.
REQ-027 ready_in reads 1 during and after reset.
REQ-028 Reset mid-group discards the partial sum; the first accept after rst_n release starts a new group.

Configuration
REQ-029 Macro ACCU_SAT_EN defined: an overflowing sum outputs 2^OUT_W-1 (saturate).
REQ-030 Macro ACCU_SAT_EN undefined: an overflowing sum outputs sum mod 2^OUT_W (wrap).
REQ-031 ovf behaves identically in both modes.

Verification
REQ-032 Defaults; samples 1,2,3,4 back-to-back, ready_out=1 -> data_out=10, valid_out=1 for one cycle, 1 cycle after the 4th accept, ovf=0.
REQ-033 Defaults; 8 samples 255 back-to-back, ready_out=1 -> data_out=1020 twice on consecutive completions, valid_out high with no bubble.
REQ-034 Defaults; ready_out=0 after group 10,10,10,10, then send 3 more samples -> data_out holds 40; ready_in drops at cnt==3; raising ready_out -> 40 transfers and the 4th sample is accepted next cycle.
REQ-035 Defaults; samples 5,6 then clr, then 1,1,1,1 -> data_out=4.
REQ-036 OUT_W=8; 4x100 -> ovf=1; data_out=255 with ACCU_SAT_EN, 144 without.
REQ-037 rst_n pulsed low after 2 of 4 samples -> outputs 0 immediately; next 4 samples 2 each -> data_out=8.

Source files
------------

// File: rtl/param_accu.sv
// ============================================================================
//  Module      : param_accu
//  Description : Accumulates N unsigned samples per group and presents the
//                group sum through a valid/ready output register with an
//                overflow flag. Build macro ACCU_SAT_EN selects saturation
//                instead of wrap on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_accu #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int OUT_W  = DATA_W + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [OUT_W-1:0]  data_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic              ovf
);

    localparam int                 c_CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(N - 1);

    // r_acc[OUT_W] is a sticky overflow bit; the low OUT_W bits carry the
    // running sum modulo 2^OUT_W, so any N/DATA_W combination stays exact.
    logic [OUT_W:0]       r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]     r_data_out;
    logic                 r_valid_out;
    logic                 r_ovf;

    logic                 w_last;
    logic                 w_ready_in;
    logic                 w_accept;
    logic                 w_complete;
    logic                 w_xfer;
    logic [OUT_W:0]       w_sum;
    logic [OUT_W:0]       w_acc_next;
    logic                 w_ovf;
    logic [OUT_W-1:0]     w_result;

    assign w_last     = (r_cnt == c_CNT_LAST);
    assign w_ready_in = !(w_last && r_valid_out && !ready_out);
    assign w_accept   = valid_in && w_ready_in;
    assign w_complete = w_accept && w_last && !clr;
    assign w_xfer     = r_valid_out && ready_out;

    assign w_sum      = {1'b0, r_acc[OUT_W-1:0]}
                      + {{(OUT_W + 1 - DATA_W){1'b0}}, data_in};
    assign w_acc_next = {r_acc[OUT_W] | w_sum[OUT_W], w_sum[OUT_W-1:0]};
    assign w_ovf      = w_acc_next[OUT_W];

`ifdef ACCU_SAT_EN
    assign w_result = w_ovf ? {OUT_W{1'b1}} : w_acc_next[OUT_W-1:0];
`else
    assign w_result = w_acc_next[OUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A completing group takes precedence over a transfer, so back-to-back
    // groups keep valid_out high without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_complete) begin
            r_data_out  <= w_result;
            r_valid_out <= 1'b1;
            r_ovf       <= w_ovf;
        end else if (w_xfer) begin
            r_valid_out <= 1'b0;
        end
    end

    assign ready_in  = w_ready_in;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_param_accu.sv
// ============================================================================
//  Module      : tb_param_accu
//  Description : Self-checking bench for param_accu (default build and
//                OUT_W=8 instance); honours ACCU_SAT_EN for expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_accu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_in;
    logic [9:0] data_out;
    logic       valid_out;
    logic       ready_out;
    logic       ovf;

    logic       b_clr;
    logic [7:0] b_data_in;
    logic       b_valid_in;
    logic       b_ready_in;
    logic [7:0] b_data_out;
    logic       b_valid_out;
    logic       b_ready_out;
    logic       b_ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] sb[$];

    always #5 clk = ~clk;

    param_accu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .ovf       (ovf)
    );

    param_accu #(.DATA_W(8), .N(4), .OUT_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (b_clr),
        .data_in   (b_data_in),
        .valid_in  (b_valid_in),
        .ready_in  (b_ready_in),
        .data_out  (b_data_out),
        .valid_out (b_valid_out),
        .ready_out (b_ready_out),
        .ovf       (b_ovf)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every output transfer pops the oldest expected group.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 1, 0);
            end else begin
                logic [10:0] e;
                e = sb.pop_front();
                check("sb_data", int'(data_out), int'(e[9:0]));
                check("sb_ovf", int'(ovf), int'(e[10]));
            end
        end
    end

    task automatic send(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = ready_in;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    typedef struct {
        logic [3:0][7:0] s;
        logic [9:0]      exp;
        logic            eovf;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{s: {8'd4, 8'd3, 8'd2, 8'd1},         exp: 10'd10,   eovf: 1'b0};
        tbl[1] = '{s: {8'd255, 8'd255, 8'd255, 8'd255}, exp: 10'd1020, eovf: 1'b0};
        tbl[2] = '{s: {8'd255, 8'd255, 8'd255, 8'd255}, exp: 10'd1020, eovf: 1'b0};
        tbl[3] = '{s: {8'd0, 8'd0, 8'd0, 8'd0},         exp: 10'd0,    eovf: 1'b0};
        tbl[4] = '{s: {8'd50, 8'd200, 8'd100, 8'd7},    exp: 10'd357,  eovf: 1'b0};

        rst_n = 1'b0; clr = 1'b0; data_in = '0; valid_in = 1'b0; ready_out = 1'b1;
        b_clr = 1'b0; b_data_in = '0; b_valid_in = 1'b0; b_ready_out = 1'b1;

        #12;
        check("rst_ready_in", int'(ready_in), 1);
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_ovf", int'(ovf), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_ready_in", int'(ready_in), 1);

        // Back-to-back groups from the vector table, latency 1.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) sb.push_back({tbl[v].eovf, tbl[v].exp});
                send(tbl[v].s[k]);
            end
            check("tbl_valid", int'(valid_out), 1);
            check("tbl_data", int'(data_out), int'(tbl[v].exp));
        end
        @(posedge clk); #1;
        check("one_cycle_valid", int'(valid_out), 0);

        // Output stall: group held, ready_in drops at last slot, then resume.
        ready_out = 1'b0;
        sb.push_back({1'b0, 10'd40});
        for (int k = 0; k < 4; k++) send(8'd10);
        for (int k = 0; k < 3; k++) send(8'd10);
        #1;
        check("stall_ready_in", int'(ready_in), 0);
        check("stall_data", int'(data_out), 40);
        valid_in = 1'b1; data_in = 8'd5;
        repeat (2) begin @(posedge clk); #1; end
        check("stall_hold_data", int'(data_out), 40);
        check("stall_hold_valid", int'(valid_out), 1);
        check("stall_hold_ready", int'(ready_in), 0);
        ready_out = 1'b1;
        sb.push_back({1'b0, 10'd35});
        send(8'd5);
        check("resume_valid", int'(valid_out), 1);
        check("resume_data", int'(data_out), 35);

        // clr discards a partial group; sample in the clr cycle is dropped.
        send(8'd5); send(8'd6);
        clr = 1'b1; valid_in = 1'b1; data_in = 8'd9;
        #1;
        check("clr_ready_in", int'(ready_in), 1);
        @(posedge clk); #1;
        clr = 1'b0; valid_in = 1'b0;
        sb.push_back({1'b0, 10'd4});
        for (int k = 0; k < 4; k++) send(8'd1);
        check("clr_data", int'(data_out), 4);

        // clr beats a completing accept.
        for (int k = 0; k < 3; k++) send(8'd3);
        clr = 1'b1; valid_in = 1'b1; data_in = 8'd3;
        @(posedge clk); #1;
        clr = 1'b0; valid_in = 1'b0;
        check("clr_complete_valid", int'(valid_out), 0);
        sb.push_back({1'b0, 10'd8});
        for (int k = 0; k < 4; k++) send(8'd2);
        check("clr_after_data", int'(data_out), 8);

        // Asynchronous reset mid-group with a pending output.
        @(posedge clk); #1;
        ready_out = 1'b0;
        for (int k = 0; k < 4; k++) send(8'd1);
        send(8'd3); send(8'd3);
        check("pre_rst_valid", int'(valid_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", int'(valid_out), 0);
        check("arst_data", int'(data_out), 0);
        check("arst_ovf", int'(ovf), 0);
        check("arst_ready_in", int'(ready_in), 1);
        @(posedge clk); #1;
        rst_n = 1'b1; ready_out = 1'b1;
        sb.push_back({1'b0, 10'd8});
        for (int k = 0; k < 4; k++) send(8'd2);
        check("arst_after_data", int'(data_out), 8);

        // Narrow-output instance: overflow and exact full-scale boundary.
        b_valid_in = 1'b1; b_data_in = 8'd100;
        repeat (4) begin @(posedge clk); #1; end
        b_valid_in = 1'b0;
        check("ovf_flag", int'(b_ovf), 1);
        check("ovf_valid", int'(b_valid_out), 1);
`ifdef ACCU_SAT_EN
        check("ovf_data", int'(b_data_out), 255);
`else
        check("ovf_data", int'(b_data_out), 144);
`endif
        b_valid_in = 1'b1; b_data_in = 8'd63;
        @(posedge clk); #1;
        b_data_in = 8'd64;
        repeat (3) begin @(posedge clk); #1; end
        b_valid_in = 1'b0;
        check("edge_ovf_flag", int'(b_ovf), 0);
        check("edge_data", int'(b_data_out), 255);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
